// File: rtl/load_ext.sv
// Registered load-data extractor/extender: lane select, zero/sign extension, one-entry output stage.
// Optional misalignment detection enabled by defining LOAD_EXT_MISALIGN_EN.
module load_ext #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              misalign
);

    logic              r_valid;
    logic [DATA_W-1:0] r_y;
    logic              r_mis;

    logic [1:0]        w_size_eff;
    logic              w_illegal;
    logic              w_full;
    logic [OFF_W-1:0]  w_align_mask;
    logic [OFF_W-1:0]  w_off_al;
    logic [DATA_W-1:0] w_lane;
    logic [7:0]        w_nbits;
    logic              w_fill;
    logic [DATA_W-1:0] w_ext;
    logic              w_mis;
    logic [DATA_W-1:0] w_y_load;
    logic              w_accept;

    // Doubleword on a 32-bit path degrades to a word access.
    assign w_illegal  = (DATA_W == 32) && (size == 2'd3);
    assign w_size_eff = w_illegal ? 2'd2 : size;
    assign w_full     = ((DATA_W == 32) && (w_size_eff == 2'd2)) ||
                        ((DATA_W == 64) && (w_size_eff == 2'd3));

    // Offset bits below the access size select nothing; they are cleared before the shift.
    assign w_align_mask = {OFF_W{1'b1}} << w_size_eff;
    assign w_off_al     = offset & w_align_mask;
    assign w_lane       = rdata >> {w_off_al, 3'b000};
    assign w_nbits      = 8'd8 << w_size_eff;

    always_comb begin
        w_fill = 1'b0;
        unique case (w_size_eff)
            2'd0:    w_fill = sign & w_lane[7];
            2'd1:    w_fill = sign & w_lane[15];
            2'd2:    w_fill = sign & w_lane[31];
            default: w_fill = sign & w_lane[DATA_W-1];
        endcase
    end

    always_comb begin
        w_ext = w_lane;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= int'(w_nbits)) begin
                w_ext[i] = w_fill;
            end
        end
        if (w_full) begin
            w_ext = rdata;
        end
    end

`ifdef LOAD_EXT_MISALIGN_EN
    assign w_mis    = w_illegal || ((offset & ~w_align_mask) != '0);
    assign w_y_load = w_mis ? '0 : w_ext;
`else
    assign w_mis    = 1'b0;
    assign w_y_load = w_ext;
`endif

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_mis   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_y     <= w_y_load;
            r_mis   <= w_mis;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign y         = r_y;
    assign misalign  = r_mis;

endmodule
